q2a03_oam_dma: RTL and testbench

Q2A03_OAM_DMA -- requirements
Module: q2a03_oam_dma

---
 rtl/q2a03_oam_dma.sv | 84 ++++++++
 tb/tb_q2a03_oam_dma.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/q2a03_oam_dma.sv
// q2a03_oam_dma: 2A03 sprite DMA engine that halts the CPU and copies a 256-byte page to the OAM data port
module q2a03_oam_dma #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_DATA = 16'h2004
) (
  input  logic        G_clock,
  input  logic        G_reset,
  input  logic        cpu_phy2,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rdwr,
  input  logic [7:0]  cpu_wr_data,
  output logic [7:0]  cpu_rd_data,
  output logic        cpu_ready,
  output logic [15:0] bus_addr,
  output logic        bus_rdwr,
  output logic [7:0]  bus_wr_data,
  input  logic [7:0]  bus_rd_data,
  output logic        dma_busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HALT  = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  logic [2:0] state_q, state_d;
  logic       parity_q, parity_d, phy2_q, phy2_d, cycle_end;
  logic [7:0] page_q, page_d, idx_q, idx_d, data_q, data_d;
  // next-state: every transition waits for the falling edge of phi2 that closes a bus cycle
  always_comb begin
    cycle_end = phy2_q & ~cpu_phy2;
    phy2_d    = cpu_phy2;
    parity_d  = parity_q ^ cycle_end;
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    data_d    = data_q;
    if (cycle_end)
      case (state_q)
        IDLE: if (cpu_addr == DMA_REG && !cpu_rdwr) begin
          page_d  = cpu_wr_data;
          idx_d   = 8'd0;
          state_d = HALT;
        end
        HALT:  if (cpu_rdwr) state_d = parity_d ? ALIGN : READ;
        ALIGN: state_d = READ;
        READ: begin
          data_d  = bus_rd_data;
          state_d = WRITE;
        end
        WRITE: begin
          state_d = (idx_q == 8'hFF) ? IDLE : READ;
          idx_d   = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;
        end
        default: state_d = IDLE;
      endcase
  end
  // state registers; reset wins over a coincident cycle end
  always_ff @(posedge G_clock) begin
    if (G_reset) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      phy2_q   <= 1'b1;
      page_q   <= 8'd0;
      idx_q    <= 8'd0;
      data_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      phy2_q   <= phy2_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end
  // bus mux: DMA owns the bus only in READ/WRITE, otherwise the CPU passes straight through
  always_comb begin
    bus_addr    = state_q == READ ? {page_q, idx_q} : state_q == WRITE ? OAM_DATA : cpu_addr;
    bus_rdwr    = state_q == READ ? 1'b1 : state_q == WRITE ? 1'b0 : cpu_rdwr;
    bus_wr_data = state_q == WRITE ? data_q : cpu_wr_data;
    cpu_rd_data = bus_rd_data;
    cpu_ready   = state_q == IDLE;
    dma_busy    = state_q != IDLE;
  end
endmodule

// File: tb/tb_q2a03_oam_dma.sv
// tb_q2a03_oam_dma: directed/randomized check of the OAM DMA against a transfer-level model
module tb_q2a03_oam_dma;
  logic        G_clock = 1'b0, G_reset = 1'b1, cpu_phy2 = 1'b1, cpu_rdwr = 1'b1, bus_rdwr, cpu_ready, dma_busy;
  logic [15:0] cpu_addr = 16'h8000, bus_addr;
  logic [7:0]  cpu_wr_data = 8'h00, cpu_rd_data, bus_wr_data, bus_rd_data;
  logic [7:0]  mem [0:65535];
  logic [15:0] s_addr;
  logic        s_rw, s_rdy, s_busy;
  logic [7:0]  s_wd, s_rd;
  int          s_par, cyc = 0, total = 0, bad = 0;

  q2a03_oam_dma dut (
    .G_clock(G_clock), .G_reset(G_reset), .cpu_phy2(cpu_phy2), .cpu_addr(cpu_addr),
    .cpu_rdwr(cpu_rdwr), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .cpu_ready(cpu_ready), .bus_addr(bus_addr), .bus_rdwr(bus_rdwr),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .dma_busy(dma_busy)
  );

  always #5 G_clock = ~G_clock;
  assign bus_rd_data = mem[bus_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one CPU bus cycle: phi2 high for a clock, then low; the falling edge ends the cycle
  task automatic cyc_run(input logic [15:0] a, input logic rw, input logic [7:0] d, input logic do_rst);
    @(negedge G_clock);
    cpu_addr = a; cpu_rdwr = rw; cpu_wr_data = d; cpu_phy2 = 1'b1; G_reset = do_rst;
    #1;
    s_addr = bus_addr; s_rw = bus_rdwr; s_wd = bus_wr_data; s_rd = cpu_rd_data;
    s_rdy = cpu_ready; s_busy = dma_busy; s_par = cyc % 2;
    @(posedge G_clock);
    if (!do_rst) begin
      @(negedge G_clock);
      cpu_phy2 = 1'b0;
      @(posedge G_clock);
      cyc++;
    end
  endtask

  // trigger a transfer, optional CPU writes while halted, then let the CPU read until released
  task automatic do_dma(input logic [7:0] pg, input int nwr, input logic wr_dma_reg);
    int lows, mism, align, j;
    logic [15:0] a;
    logic [7:0] d;
    logic done;
    cyc_run(16'h4014, 1'b0, pg, 1'b0);
    chk("trig addr", {16'h0, s_addr}, 32'h4014);
    chk("trig rw", {31'h0, s_rw}, 32'h0);
    chk("trig data", {24'h0, s_wd}, {24'h0, pg});
    chk("trig ready", {31'h0, s_rdy}, 32'h1);
    for (int w = 0; w < nwr; w++) begin
      a = wr_dma_reg ? 16'h4014 : {8'h01, 8'($urandom_range(0, 255))};
      d = wr_dma_reg ? ~pg : 8'($urandom_range(0, 255));
      cyc_run(a, 1'b0, d, 1'b0);
      chk("halt wr ready", {31'h0, s_rdy}, 32'h0);
      chk("halt wr busy", {31'h0, s_busy}, 32'h1);
      chk("halt wr addr", {16'h0, s_addr}, {16'h0, a});
      chk("halt wr data", {23'h0, s_rw, s_wd}, {24'h0, d});
    end
    align = (cyc % 2 == 0) ? 1 : 0;
    lows = 0; mism = 0; done = 1'b0;
    for (int k = 0; k < 600 && !done; k++) begin
      cyc_run(16'h8000, 1'b1, 8'h00, 1'b0);
      if (s_rdy) done = 1'b1;
      else begin
        lows++;
        if (k < 1 + align) begin
          if (s_addr !== 16'h8000 || s_rw !== 1'b1) mism++;
        end else if (k - 1 - align >= 512) mism++;
        else begin
          j = k - 1 - align;
          a = {pg, 8'(j / 2)};
          if (j % 2 == 0) begin
            if (s_addr !== a || s_rw !== 1'b1 || s_par != 0 || s_rd !== mem[a]) mism++;
          end else if (s_addr !== 16'h2004 || s_rw !== 1'b0 || s_wd !== mem[a]) mism++;
        end
      end
    end
    chk("ready low cycles", lows, 513 + align);
    chk("dma bus sequence errors", mism, 0);
    chk("idle busy", {31'h0, s_busy}, 32'h0);
  endtask

  initial begin
    int kk, nw, align;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
    repeat (3) @(posedge G_clock);
    @(negedge G_clock);
    cpu_addr = 16'h1234; cpu_rdwr = 1'b0; cpu_wr_data = 8'hA5;
    #1;
    chk("rst ready", {31'h0, cpu_ready}, 32'h1);
    chk("rst busy", {31'h0, dma_busy}, 32'h0);
    chk("rst addr", {16'h0, bus_addr}, 32'h1234);
    chk("rst rw", {31'h0, bus_rdwr}, 32'h0);
    chk("rst wdata", {24'h0, bus_wr_data}, 32'hA5);
    G_reset = 1'b0;
    cyc_run(16'h4015, 1'b0, 8'h02, 1'b0);
    cyc_run(16'h4014, 1'b1, 8'h00, 1'b0);
    chk("4015 write busy", {31'h0, s_busy}, 32'h0);
    cyc_run(16'h8000, 1'b1, 8'h00, 1'b0);
    chk("4014 read busy", {31'h0, s_busy}, 32'h0);
    chk("4014 read ready", {31'h0, s_rdy}, 32'h1);
    if (cyc % 2 != 0) cyc_run(16'h8000, 1'b1, 8'h00, 1'b0);
    do_dma(8'h02, 0, 1'b0);
    if (cyc % 2 == 0) cyc_run(16'h8000, 1'b1, 8'h00, 1'b0);
    do_dma(8'h02, 0, 1'b0);
    do_dma(8'h02, 2, 1'b0);
    for (int i = 0; i < 256; i++) mem[16'h0700 + i] = 8'(i) ^ 8'h5A;
    do_dma(8'h07, 1, 1'b1);
    cyc_run(16'h4014, 1'b0, 8'h02, 1'b0);
    align = (cyc % 2 == 0) ? 1 : 0;
    kk = 1 + align + 2 * 8'h40 + 1;
    for (int k = 0; k < kk; k++) cyc_run(16'h8000, 1'b1, 8'h00, 1'b0);
    cyc_run(16'h8000, 1'b1, 8'h00, 1'b1);
    chk("pre-rst write addr", {16'h0, s_addr}, 32'h2004);
    chk("pre-rst write data", {24'h0, s_wd}, {24'h0, mem[16'h0240]});
    @(negedge G_clock);
    #1;
    chk("abort ready", {31'h0, cpu_ready}, 32'h1);
    chk("abort busy", {31'h0, dma_busy}, 32'h0);
    chk("abort addr", {16'h0, bus_addr}, 32'h8000);
    chk("abort rw", {31'h0, bus_rdwr}, 32'h1);
    G_reset = 1'b0;
    cyc = 0;
    nw = 0;
    repeat (20) begin
      cyc_run(16'h8000, 1'b1, 8'h00, 1'b0);
      if (s_addr == 16'h2004 && !s_rw) nw++;
    end
    chk("writes after abort", nw, 0);
    chk("ready after abort", {31'h0, s_rdy}, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
